icap_byte_loader: RTL and testbench
===================================

ICAP_BYTE_LOADER -- requirements
Module: icap_byte_loader

Interface
REQ-001 SHALL have parameter LEN_W, default 16, command byte-count width.
REQ-002 SHALL have parameter BITSWAP, default 1; 1 = reverse bit order within each byte on ICAP_I and ICAP_O, 0 = pass-through.
REQ-003 SHALL have parameter BUSY_TMO, default 255, max consecutive BUSY cycles before abort.
REQ-004 SHALL have ports, clock and reset first:
  CLK  in  1  single clock, rising edge
  RST_N  in  1  asynchronous active-low reset
  CMD_VALID  in  1  command offered
  CMD_READY  out  1  command accepted when both high
  CMD_RD  in  1  0 = configure (write), 1 = readback
  CMD_LEN  in  LEN_W  byte count
  WR_DATA  in  8  config byte
  WR_VALID  in  1  / WR_READY  out  1  write stream handshake
  RD_DATA  out  8  readback byte
  RD_VALID  out  1  / RD_READY  in  1  read stream handshake
  DONE  out  1  one-cycle pulse, command finished
  ERR  out  1  sticky BUSY-timeout flag
  ICAP_CE_N  out  1  ICAP chip enable, active low
  ICAP_WRITE_N  out  1  ICAP direction, 0 = write
  ICAP_I  out  8  data to ICAP
  ICAP_O  in  8  data from ICAP
  ICAP_BUSY  in  1  ICAP busy

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ, TURN.
REQ-006 IDLE: CMD_READY=1; on CMD_VALID latch CMD_LEN into remaining counter, clear ERR, go WRITE (CMD_RD=0) or READ (CMD_RD=1); CMD_LEN=0 SHALL go directly to TURN.
REQ-007 ICAP_CE_N, ICAP_WRITE_N, ICAP_I SHALL be registered outputs.
REQ-008 A transfer SHALL occur on a rising edge where ICAP_CE_N=0 and ICAP_BUSY=0; only transfers decrement remaining.
REQ-009 WRITE: ICAP_WRITE_N=0; WR_READY = (remaining not yet all loaded) and (ICAP_CE_N=1 or ICAP_BUSY=0); on WR handshake load ICAP_I=swap(WR_DATA), ICAP_CE_N=0 next cycle.
REQ-010 WRITE: while ICAP_BUSY=1 with ICAP_CE_N=0, ICAP_I and ICAP_CE_N SHALL hold unchanged.
REQ-011 WRITE: if no new byte is available when the current byte transfers, ICAP_CE_N SHALL return to 1 next cycle (gaps allowed, no duplicate bytes).
REQ-012 READ: ICAP_WRITE_N=1; ICAP_CE_N=0 only while remaining>0 and the single-entry output register is empty or being drained this cycle.
REQ-013 READ: on each transfer capture RD_DATA=swap(ICAP_O), set RD_VALID; RD_VALID clears on RD_READY unless a new byte is captured the same cycle.
REQ-014 Leaving WRITE/READ when remaining reaches 0 (and, for READ, RD_VALID drained) SHALL enter TURN.
REQ-015 TURN SHALL hold ICAP_CE_N=1 for exactly 2 cycles, ICAP_WRITE_N unchanged, then return to IDLE with ICAP_WRITE_N=1 and DONE=1 for one cycle.
REQ-016 BUSY counter SHALL count consecutive cycles ICAP_BUSY=1 with ICAP_CE_N=0; reaching BUSY_TMO SHALL set ERR, drop ICAP_CE_N, discard remaining, enter TURN.
REQ-017 ERR SHALL remain set until the next command is accepted; DONE still pulses after timeout abort.
REQ-018 Remaining counter SHALL be LEN_W bits, never wrap below 0.

Reset
REQ-019 On RST_N low, asynchronously: state IDLE, ICAP_CE_N=1, ICAP_WRITE_N=1, ICAP_I=0, RD_DATA=0, RD_VALID=0, DONE=0, ERR=0, counters 0.
REQ-020 Reset mid-transfer SHALL abort with no further ICAP activity; CMD_READY=1 on first cycle after release.

Structure
REQ-021 State enum and the bit-swap function SHALL live in shared package icap_pkg.
REQ-022 BUSY timeout counter SHALL be sub-module icap_busy_timer (inputs CLK, RST_N, CLR, BUSY_ACT; output EXPIRED).

Verification
REQ-023 Write CMD_LEN=4, bytes 0xAA,0x99,0x55,0x66, BITSWAP=1, BUSY=0 -> ICAP_I sees 0x55,0x99,0xAA,0x66 on 4 CE_N=0 cycles, DONE 2 cycles after last transfer+TURN.
REQ-024 Write 3 bytes with BUSY=1 for 5 cycles on byte 2 -> ICAP_I holds byte 2 stable, exactly 3 transfers, ERR=0.
REQ-025 Readback CMD_LEN=3, RD_READY low 4 cycles after first byte -> CE_N=1 during stall, 3 RD bytes in order, none lost.
REQ-026 BUSY stuck high with BUSY_TMO=8 -> ERR=1 after 8 cycles, CE_N=1, DONE pulse, next command clears ERR.
REQ-027 CMD_LEN=0 -> no CE_N activity, DONE after 2 TURN cycles; RST_N low mid-write -> CE_N=1 immediately.

Source files
------------

// File: rtl/icap_pkg.sv
// Shared types and helpers for the ICAP byte loader.
package icap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_e;

    // Xilinx ICAP wants bit 0 of each byte on the MSB lane.
    function automatic logic [7:0] swap_bits(input logic [7:0] b, input logic en);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return en ? r : b;
    endfunction

endpackage

// File: rtl/icap_busy_timer.sv
// Consecutive-BUSY watchdog: EXPIRED pulses on the BUSY_TMO-th back-to-back active cycle.
module icap_busy_timer #(
    parameter int BUSY_TMO = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    input  logic BUSY_ACT,
    output logic EXPIRED
);

    localparam int CNT_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(BUSY_TMO - 1);

    logic [CNT_W-1:0] cnt_q;

    assign EXPIRED = BUSY_ACT && !CLR && (cnt_q == '0);

    // Down-counter reloads on any idle cycle, so only an unbroken busy run reaches zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (CLR || !BUSY_ACT || EXPIRED) begin
            cnt_q <= TC_LOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/icap_byte_loader.sv
// Byte-wide ICAP command engine: streams configuration bytes in or readback bytes out.
//  state | meaning
//  IDLE  | waiting for a command, CMD_READY high
//  WRITE | loading config bytes onto ICAP_I, one transfer per byte
//  READ  | strobing ICAP for readback bytes into the output register
//  TURN  | two CE_N-high cycles before returning to IDLE with DONE
module icap_byte_loader
    import icap_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int BITSWAP  = 1,
    parameter int BUSY_TMO = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_RD,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic [7:0]       WR_DATA,
    input  logic             WR_VALID,
    output logic             WR_READY,
    output logic [7:0]       RD_DATA,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic             DONE,
    output logic             ERR,
    output logic             ICAP_CE_N,
    output logic             ICAP_WRITE_N,
    output logic [7:0]       ICAP_I,
    input  logic [7:0]       ICAP_O,
    input  logic             ICAP_BUSY
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, rem_next;
    logic             ce_n_q, write_n_q, rd_valid_q, done_q, err_q, turn_cnt_q;
    logic [7:0]       icap_i_q, rd_data_q;

    logic transfer, rd_capture, rd_valid_next, busy_act, timeout, cmd_accept, wr_hs;
    logic cmd_ready, wr_ready;

    assign transfer      = !ce_n_q && !ICAP_BUSY;
    assign rem_next      = (transfer && remaining_q != '0) ? remaining_q - LEN_W'(1) : remaining_q;
    assign rd_capture    = (state_q == READ) && transfer;
    assign rd_valid_next = rd_capture || (rd_valid_q && !RD_READY);
    assign busy_act      = !ce_n_q && ICAP_BUSY && ((state_q == WRITE) || (state_q == READ));
    assign cmd_accept    = (state_q == IDLE) && CMD_VALID;
    assign wr_hs         = WR_VALID && wr_ready;

    icap_busy_timer #(
        .BUSY_TMO (BUSY_TMO)
    ) u_busy_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLR      (cmd_accept),
        .BUSY_ACT (busy_act),
        .EXPIRED  (timeout)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_LEN == '0)  state_d = TURN;
                    else if (CMD_RD)    state_d = READ;
                    else                state_d = WRITE;
                end
            end
            WRITE: begin
                if (timeout || rem_next == '0) state_d = TURN;
            end
            READ: begin
                if (timeout || (rem_next == '0 && !rd_valid_next)) state_d = TURN;
            end
            TURN: begin
                if (turn_cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new byte may load when an unloaded byte remains and ICAP_I is free or transferring now.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        wr_ready  = 1'b0;
        if (state_q == WRITE) begin
            if (ce_n_q) wr_ready = (remaining_q != '0);
            else        wr_ready = !ICAP_BUSY && (remaining_q > LEN_W'(1));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            remaining_q <= '0;
            ce_n_q      <= 1'b1;
            write_n_q   <= 1'b1;
            icap_i_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            turn_cnt_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= rd_valid_next;
            if (rd_capture) begin
                rd_data_q <= swap_bits(ICAP_O, BITSWAP != 0);
            end
            case (state_q)
                IDLE: begin
                    if (cmd_accept) begin
                        remaining_q <= CMD_LEN;
                        err_q       <= 1'b0;
                        write_n_q   <= CMD_RD;
                        ce_n_q      <= 1'b1;
                    end
                end
                WRITE: begin
                    if (timeout) begin
                        ce_n_q      <= 1'b1;
                        remaining_q <= '0;
                        err_q       <= 1'b1;
                    end else begin
                        remaining_q <= rem_next;
                        if (wr_hs) begin
                            icap_i_q <= swap_bits(WR_DATA, BITSWAP != 0);
                            ce_n_q   <= 1'b0;
                        end else if (transfer) begin
                            ce_n_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (timeout) begin
                        ce_n_q      <= 1'b1;
                        remaining_q <= '0;
                        err_q       <= 1'b1;
                    end else begin
                        // Only strobe when the captured byte is guaranteed a free slot.
                        remaining_q <= rem_next;
                        ce_n_q      <= !((rem_next != '0) && !rd_valid_next);
                    end
                end
                TURN: begin
                    ce_n_q     <= 1'b1;
                    turn_cnt_q <= ~turn_cnt_q;
                    if (turn_cnt_q) begin
                        write_n_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CMD_READY    = cmd_ready;
    assign WR_READY     = wr_ready;
    assign RD_DATA      = rd_data_q;
    assign RD_VALID     = rd_valid_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign ICAP_CE_N    = ce_n_q;
    assign ICAP_WRITE_N = write_n_q;
    assign ICAP_I       = icap_i_q;

endmodule

// File: tb/tb_icap_byte_loader.sv
// Scoreboard bench for icap_byte_loader: write, readback, BUSY hold/timeout, zero length, reset.
module tb_icap_byte_loader;

    localparam int LEN_W = 16;
    localparam int TMO   = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic             CMD_RD = 1'b0;
    logic [LEN_W-1:0] CMD_LEN = '0;
    logic [7:0]       WR_DATA = '0;
    logic             WR_VALID = 1'b0;
    logic             WR_READY;
    logic [7:0]       RD_DATA;
    logic             RD_VALID;
    logic             RD_READY = 1'b1;
    logic             DONE;
    logic             ERR;
    logic             ICAP_CE_N;
    logic             ICAP_WRITE_N;
    logic [7:0]       ICAP_I;
    logic [7:0]       ICAP_O;
    logic             ICAP_BUSY = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] wr_src[$];
    logic [7:0] rd_idx = 8'd0;

    always #5 CLK = ~CLK;

    icap_byte_loader #(
        .LEN_W    (LEN_W),
        .BITSWAP  (1),
        .BUSY_TMO (TMO)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD_RD       (CMD_RD),
        .CMD_LEN      (CMD_LEN),
        .WR_DATA      (WR_DATA),
        .WR_VALID     (WR_VALID),
        .WR_READY     (WR_READY),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .RD_READY     (RD_READY),
        .DONE         (DONE),
        .ERR          (ERR),
        .ICAP_CE_N    (ICAP_CE_N),
        .ICAP_WRITE_N (ICAP_WRITE_N),
        .ICAP_I       (ICAP_I),
        .ICAP_O       (ICAP_O),
        .ICAP_BUSY    (ICAP_BUSY)
    );

    function automatic logic [7:0] icap_model(input logic [7:0] i);
        return 8'(i * 8'd37 + 8'd19);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // ICAP readback model: next byte presented after each read transfer.
    assign ICAP_O = icap_model(rd_idx);
    always @(posedge CLK) begin
        if (!ICAP_CE_N && !ICAP_BUSY && ICAP_WRITE_N) rd_idx <= rd_idx + 8'd1;
    end

    task automatic send_cmd(input logic rd, input int len);
        @(posedge CLK); #1;
        CMD_VALID = 1'b1;
        CMD_RD    = rd;
        CMD_LEN   = LEN_W'(len);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic run_write(input int busy_at, input int busy_len,
                             output int n_xfer, output int n_ce_low, output int n_busy,
                             output int done_gap, output logic err_at_done, output logic wn_at_done);
        int widx = 0;
        int busy_left = 0;
        int last_xfer = 0;
        bit trig = 0;
        bit got_done = 0;
        logic [7:0] e;
        n_xfer = 0; n_ce_low = 0; n_busy = 0; done_gap = -1;
        err_at_done = 1'bx; wn_at_done = 1'bx;
        WR_VALID = (wr_src.size() > 0);
        WR_DATA  = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
        send_cmd(1'b0, wr_src.size());
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!trig && busy_len > 0 && !ICAP_CE_N && n_xfer == busy_at) begin
                busy_left = busy_len;
                trig = 1;
            end
            ICAP_BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            @(negedge CLK);
            if (!ICAP_CE_N) n_ce_low++;
            if (!ICAP_CE_N && ICAP_BUSY && exp_q.size() > 0) begin
                n_busy++;
                n_cmp++;
                if (ICAP_I !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL icap_i_hold: got %h want %h", ICAP_I, exp_q[0]);
                end
            end
            if (!ICAP_CE_N && !ICAP_BUSY) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++;
                if (ICAP_I !== e || ICAP_WRITE_N !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_xfer[%0d]: got %h/wn=%b want %h/wn=0", n_xfer, ICAP_I, ICAP_WRITE_N, e);
                end
                n_xfer++;
                last_xfer = cyc;
            end
            if (DONE) begin
                got_done = 1;
                done_gap = cyc - last_xfer;
                err_at_done = ERR;
                wn_at_done = ICAP_WRITE_N;
                break;
            end
            if (WR_VALID && WR_READY) widx++;
            @(posedge CLK); #1;
            WR_VALID = (widx < wr_src.size());
            WR_DATA  = (widx < wr_src.size()) ? wr_src[widx] : 8'h00;
        end
        ICAP_BUSY = 1'b0;
        WR_VALID  = 1'b0;
        n_cmp++;
        if (!got_done) begin
            n_err++;
            $display("FAIL wr_done_timeout: got no DONE want DONE within 200 cycles");
        end
        exp_q.delete();
    endtask

    task automatic run_read(input int n, input int stall_len, output int n_xfer, output int n_rx);
        int stall_left = 0;
        bit stalled = 0;
        bit got_done = 0;
        logic [7:0] k;
        logic [7:0] e;
        n_xfer = 0; n_rx = 0;
        for (int i = 0; i < n; i++) begin
            k = rd_idx + 8'(i);
            exp_q.push_back(rev8(icap_model(k)));
        end
        RD_READY = 1'b1;
        send_cmd(1'b1, n);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!stalled && stall_len > 0 && RD_VALID) begin
                stall_left = stall_len;
                stalled = 1;
            end
            RD_READY = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge CLK);
            if (!RD_READY) begin
                n_cmp++;
                if (ICAP_CE_N !== 1'b1) begin
                    n_err++;
                    $display("FAIL rd_stall_ce_n: got %b want 1", ICAP_CE_N);
                end
            end
            if (!ICAP_CE_N && !ICAP_BUSY) n_xfer++;
            if (RD_VALID && RD_READY) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++;
                if (RD_DATA !== e) begin
                    n_err++;
                    $display("FAIL rd_byte[%0d]: got %h want %h", n_rx, RD_DATA, e);
                end
                n_rx++;
            end
            if (DONE) begin
                got_done = 1;
                break;
            end
            @(posedge CLK); #1;
        end
        RD_READY = 1'b1;
        n_cmp++;
        if (!got_done || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rd_done: got done=%0d left=%0d want done=1 left=0", got_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({CMD_READY, ICAP_CE_N, ICAP_WRITE_N, ICAP_I, RD_VALID, RD_DATA, DONE, ERR, WR_READY}
            !== {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b ce=%b wn=%b i=%h rv=%b rd=%h done=%b err=%b wrr=%b want 1 1 1 00 0 00 0 0 0",
                     CMD_READY, ICAP_CE_N, ICAP_WRITE_N, ICAP_I, RD_VALID, RD_DATA, DONE, ERR, WR_READY);
        end
    endtask

    task automatic test_write_basic();
        int nx, nce, nb, gap;
        logic er, wn;
        wr_src = '{8'hAA, 8'h99, 8'h55, 8'h66};
        exp_q  = '{8'h55, 8'h99, 8'hAA, 8'h66};
        run_write(-1, 0, nx, nce, nb, gap, er, wn);
        n_cmp++;
        if (nx != 4 || nce != 4) begin
            n_err++;
            $display("FAIL wr_basic_count: got xfer=%0d ce_low=%0d want 4 4", nx, nce);
        end
        n_cmp++;
        if (gap != 3 || er !== 1'b0 || wn !== 1'b1) begin
            n_err++;
            $display("FAIL wr_basic_done: got gap=%0d err=%b wn=%b want 3 0 1", gap, er, wn);
        end
    endtask

    task automatic test_write_busy();
        int nx, nce, nb, gap;
        logic er, wn;
        wr_src = '{8'h12, 8'h34, 8'hC3};
        exp_q.delete();
        foreach (wr_src[i]) exp_q.push_back(rev8(wr_src[i]));
        run_write(1, 5, nx, nce, nb, gap, er, wn);
        n_cmp++;
        if (nx != 3 || nb != 5 || er !== 1'b0) begin
            n_err++;
            $display("FAIL wr_busy: got xfer=%0d busy=%0d err=%b want 3 5 0", nx, nb, er);
        end
    endtask

    task automatic test_read_stall();
        int nx, nr;
        run_read(3, 4, nx, nr);
        n_cmp++;
        if (nx != 3 || nr != 3) begin
            n_err++;
            $display("FAIL rd_stall_count: got xfer=%0d rx=%0d want 3 3", nx, nr);
        end
    endtask

    task automatic test_back_to_back();
        int nx, nr, nce, nb, gap;
        logic er, wn;
        run_read(5, 0, nx, nr);
        n_cmp++;
        if (nx != 5 || nr != 5) begin
            n_err++;
            $display("FAIL b2b_read: got xfer=%0d rx=%0d want 5 5", nx, nr);
        end
        wr_src = '{8'h01, 8'h80};
        exp_q  = '{8'h80, 8'h01};
        run_write(-1, 0, nx, nce, nb, gap, er, wn);
        n_cmp++;
        if (nx != 2 || gap != 3) begin
            n_err++;
            $display("FAIL b2b_write: got xfer=%0d gap=%0d want 2 3", nx, gap);
        end
    endtask

    task automatic test_busy_timeout();
        int nx, nce, nb, gap;
        logic er, wn;
        wr_src = '{8'hF0, 8'h0F};
        exp_q  = '{8'h0F, 8'hF0};
        run_write(0, 1000, nx, nce, nb, gap, er, wn);
        n_cmp++;
        if (nb != TMO || nce != TMO || nx != 0) begin
            n_err++;
            $display("FAIL tmo_count: got busy=%0d ce_low=%0d xfer=%0d want 8 8 0", nb, nce, nx);
        end
        n_cmp++;
        if (er !== 1'b1 || ICAP_CE_N !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_err: got err=%b ce=%b want 1 1", er, ICAP_CE_N);
        end
    endtask

    task automatic test_len_zero();
        int nce = 0;
        int pos = -1;
        send_cmd(1'b0, 0);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                n_cmp++;
                if (ERR !== 1'b0) begin
                    n_err++;
                    $display("FAIL len0_err_clear: got %b want 0", ERR);
                end
            end
            if (!ICAP_CE_N) nce++;
            if (DONE) begin
                pos = cyc;
                break;
            end
        end
        n_cmp++;
        if (nce != 0 || pos != 3) begin
            n_err++;
            $display("FAIL len0: got ce_low=%0d done_at=%0d want 0 3", nce, pos);
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 0;
        int nce = 0;
        wr_src   = '{8'h01, 8'h02, 8'h03, 8'h04};
        WR_VALID = 1'b1;
        WR_DATA  = wr_src[0];
        send_cmd(1'b0, 4);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (!ICAP_CE_N) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_mid_start: got no CE_N low want CE_N low within 10 cycles");
        end
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if (ICAP_CE_N !== 1'b1 || ICAP_WRITE_N !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async: got ce=%b wn=%b want 1 1", ICAP_CE_N, ICAP_WRITE_N);
        end
        WR_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (CMD_READY !== 1'b1 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release: got rdy=%b err=%b want 1 0", CMD_READY, ERR);
        end
        repeat (4) begin
            @(negedge CLK);
            if (!ICAP_CE_N) nce++;
        end
        n_cmp++;
        if (nce != 0) begin
            n_err++;
            $display("FAIL rst_quiet: got ce_low=%0d want 0", nce);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_busy();
        test_read_stall();
        test_back_to_back();
        test_busy_timeout();
        test_len_zero();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
